// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one registered AXI-stream output among NUM_PORTS sources.
// Optional macro AXIS_ARB_SRC_TAG_EN stamps the granted port index into the low bits of m_user.
module axis_pkt_arbiter #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEST_WIDTH = 7,
    parameter int unsigned USER_WIDTH = 7
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]       s_data,
    input  logic [NUM_PORTS*DEST_WIDTH-1:0]       s_dest,
    input  logic [NUM_PORTS*(DATA_WIDTH>>3)-1:0]  s_keep,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]       s_user,
    input  logic [NUM_PORTS-1:0]                  s_last,
    input  logic [NUM_PORTS-1:0]                  s_valid,
    output logic [NUM_PORTS-1:0]                  s_ready,
    output logic [DATA_WIDTH-1:0]                 m_data,
    output logic [DEST_WIDTH-1:0]                 m_dest,
    output logic [(DATA_WIDTH>>3)-1:0]            m_keep,
    output logic [USER_WIDTH-1:0]                 m_user,
    output logic                                  m_last,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [$clog2(NUM_PORTS)-1:0]          grant_idx,
    output logic                                  busy
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH >> 3;
    localparam int unsigned IDX_W      = $clog2(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       cand;
    logic                   pick_vld;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   accept;

    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic [DEST_WIDTH-1:0]  m_dest_q, m_dest_d;
    logic [KEEP_WIDTH-1:0]  m_keep_q, m_keep_d;
    logic [USER_WIDTH-1:0]  m_user_q, m_user_d;
    logic [USER_WIDTH-1:0]  user_c;

`ifdef AXIS_ARB_SRC_TAG_EN
    if (USER_WIDTH < IDX_W) begin : g_user_width_chk
        $error("axis_pkt_arbiter: USER_WIDTH too narrow to carry the source tag");
    end
`endif

    // Round-robin pick: first requester after the last completed grant, with wrap.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last_grant_q;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = IDX_W'((32'(last_grant_q) + i) % NUM_PORTS);
            if (!pick_vld && s_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign sel_valid = s_valid[grant_q];
    assign sel_last  = s_last[grant_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= LAST_IDX;
            last_grant_q <= LAST_IDX;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the granted port sees ready, and only when the output slot is free or draining.
    always_comb begin
        s_ready = '0;
        accept  = 1'b0;
        if (state_q == BUSY) begin
            s_ready[grant_q] = ~m_valid_q | m_ready;
            accept           = sel_valid & (~m_valid_q | m_ready);
        end
    end

    always_comb begin
        m_valid_d = m_valid_q & ~m_ready;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        m_dest_d  = m_dest_q;
        m_keep_d  = m_keep_q;
        m_user_d  = m_user_q;
        user_c    = s_user[32'(grant_q)*USER_WIDTH +: USER_WIDTH];
`ifdef AXIS_ARB_SRC_TAG_EN
        user_c[IDX_W-1:0] = grant_q;
`endif
        if (accept) begin
            m_valid_d = 1'b1;
            m_last_d  = sel_last;
            m_data_d  = s_data[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            m_dest_d  = s_dest[32'(grant_q)*DEST_WIDTH +: DEST_WIDTH];
            m_keep_d  = s_keep[32'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
            m_user_d  = user_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_dest_q  <= '0;
            m_keep_q  <= '0;
            m_user_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            m_dest_q  <= m_dest_d;
            m_keep_q  <= m_keep_d;
            m_user_q  <= m_user_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_data    = m_data_q;
    assign m_dest    = m_dest_q;
    assign m_keep    = m_keep_q;
    assign m_user    = m_user_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_axis_pkt_arbiter;

    localparam int NP   = 4;
    localparam int DW   = 64;
    localparam int KW   = 8;
    localparam int DSTW = 7;
    localparam int UW   = 7;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NP*DW-1:0]     s_data;
    logic [NP*DSTW-1:0]   s_dest;
    logic [NP*KW-1:0]     s_keep;
    logic [NP*UW-1:0]     s_user;
    logic [NP-1:0]        s_last;
    logic [NP-1:0]        s_valid;
    logic [NP-1:0]        s_ready;
    logic [DW-1:0]        m_data;
    logic [DSTW-1:0]      m_dest;
    logic [KW-1:0]        m_keep;
    logic [UW-1:0]        m_user;
    logic                 m_last;
    logic                 m_valid;
    logic                 m_ready;
    logic [1:0]           grant_idx;
    logic                 busy;

    axis_pkt_arbiter #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .DEST_WIDTH(DSTW),
        .USER_WIDTH(UW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_dest   (s_dest),
        .s_keep   (s_keep),
        .s_user   (s_user),
        .s_last   (s_last),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_dest   (m_dest),
        .m_keep   (m_keep),
        .m_user   (m_user),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .grant_idx(grant_idx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DSTW-1:0] dest;
        logic [KW-1:0]   keep;
        logic [UW-1:0]   user;
        logic            last;
    } beat_t;

    beat_t       src_q [NP][$];
    bit          stall [NP];
    int unsigned valid_pct = 100;
    int unsigned ready_pct = 100;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // Transaction-level reference: who owns the output, who finished last, what sits in the output slot.
    bit          md_busy;
    bit          md_ov;
    int          md_owner;
    int          md_last;
    beat_t       md_out;

    logic [DW-1:0] log_data [$];
    bit            log_last [$];
    int            log_cyc  [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_busy  = 1'b0;
        md_ov    = 1'b0;
        md_owner = NP - 1;
        md_last  = NP - 1;
        md_out   = '0;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    task automatic add_beat(input int p, input logic [DW-1:0] d, input logic [UW-1:0] u, input bit l);
        beat_t b;
        b.data = d;
        b.dest = DSTW'($urandom);
        b.keep = KW'($urandom);
        b.user = u;
        b.last = l;
        src_q[p].push_back(b);
    endtask

    task automatic add_pkt(input int p, input int len, input logic [DW-1:0] base);
        for (int i = 0; i < len; i++)
            add_beat(p, base + DW'(i), UW'($urandom), (i == len - 1));
    endtask

    task automatic add_rand_pkt();
        int p;
        int len;
        p   = int'($urandom_range(NP - 1));
        len = int'($urandom_range(5, 1));
        for (int i = 0; i < len; i++)
            add_beat(p, {$urandom, $urandom}, UW'($urandom), (i == len - 1));
    endtask

    // One clock: drive sources, compare DUT against the model, then advance the model.
    task automatic cycle(input bit do_rst);
        bit            vld [NP];
        beat_t         hd;
        beat_t         b;
        logic [NP-1:0] exp_rdy;
        bit            mr;
        bit            acc;
        bit            was_busy;
        bit            found;
        int            nxt;
        rst     = do_rst;
        mr      = ($urandom_range(99) < ready_pct);
        m_ready = mr;
        for (int p = 0; p < NP; p++) begin
            vld[p] = !stall[p] && (src_q[p].size() > 0) && ($urandom_range(99) < valid_pct);
            hd = (src_q[p].size() > 0) ? src_q[p][0] : beat_t'(0);
            s_data[p*DW +: DW]     = hd.data;
            s_dest[p*DSTW +: DSTW] = hd.dest;
            s_keep[p*KW +: KW]     = hd.keep;
            s_user[p*UW +: UW]     = hd.user;
            s_last[p]              = hd.last;
            s_valid[p]             = vld[p];
        end
        #1;
        exp_rdy = '0;
        if (md_busy) exp_rdy[md_owner] = !md_ov || mr;
        chk("m_valid", 64'(m_valid), 64'(md_ov));
        if (md_ov) begin
            chk("m_data", 64'(m_data), 64'(md_out.data));
            chk("m_dest", 64'(m_dest), 64'(md_out.dest));
            chk("m_keep", 64'(m_keep), 64'(md_out.keep));
            chk("m_user", 64'(m_user), 64'(md_out.user));
            chk("m_last", 64'(m_last), 64'(md_out.last));
        end
        chk("busy", 64'(busy), 64'(md_busy));
        chk("grant_idx", 64'(grant_idx), 64'(md_owner));
        chk("s_ready", 64'(s_ready), 64'(exp_rdy));
        if (m_valid && m_ready) begin
            log_data.push_back(m_data);
            log_last.push_back(m_last);
            log_cyc.push_back(cyc);
        end
        acc      = md_busy && vld[md_owner] && exp_rdy[md_owner];
        was_busy = md_busy;
        if (do_rst) begin
            model_reset();
        end else begin
            if (acc) begin
                b = src_q[md_owner].pop_front();
                md_out = b;
`ifdef AXIS_ARB_SRC_TAG_EN
                md_out.user[1:0] = 2'(md_owner);
`endif
                md_ov = 1'b1;
                if (b.last) begin
                    md_busy = 1'b0;
                    md_last = md_owner;
                end
            end else if (md_ov && mr) begin
                md_ov = 1'b0;
            end
            if (!was_busy) begin
                found = 1'b0;
                for (int i = 1; i <= NP; i++) begin
                    nxt = (md_last + i) % NP;
                    if (!found && vld[nxt]) begin
                        found    = 1'b1;
                        md_owner = nxt;
                        md_busy  = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  k;
        bit  pending;
        logic [63:0] exp_user;

        rst = 1'b1; m_ready = 1'b1;
        s_data = '0; s_dest = '0; s_keep = '0; s_user = '0; s_last = '0; s_valid = '0;
        for (int p = 0; p < NP; p++) stall[p] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        s_valid = '1;
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_dest", 64'(m_dest), 64'd0);
        chk("rst_m_keep", 64'(m_keep), 64'd0);
        chk("rst_m_user", 64'(m_user), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_idx), 64'd3);

        // Single port, three-beat packet.
        clear_log();
        add_beat(0, 64'h11, 7'h01, 1'b0);
        add_beat(0, 64'h22, 7'h02, 1'b0);
        add_beat(0, 64'h33, 7'h03, 1'b1);
        cycle(1'b0);
        chk("t1_busy_granted", 64'(busy), 64'd1);
        chk("t1_grant", 64'(grant_idx), 64'd0);
        chk("t1_no_early_valid", 64'(m_valid), 64'd0);
        cycle(1'b0);
        chk("t1_first_valid", 64'(m_valid), 64'd1);
        chk("t1_beat0", 64'(m_data), 64'h11);
        chk("t1_last0", 64'(m_last), 64'd0);
        cycle(1'b0);
        chk("t1_beat1", 64'(m_data), 64'h22);
        cycle(1'b0);
        chk("t1_beat2", 64'(m_data), 64'h33);
        chk("t1_last2", 64'(m_last), 64'd1);
        chk("t1_busy_drop", 64'(busy), 64'd0);
        cycle(1'b0);
        chk("t1_drained", 64'(m_valid), 64'd0);
        chk("t1_log_n", 64'(log_data.size()), 64'd3);
        if (log_data.size() == 3) begin
            chk("t1_log0", log_data[0], 64'h11);
            chk("t1_log2", log_data[2], 64'h33);
            chk("t1_log_last", {61'd0, log_last[0], log_last[1], log_last[2]}, 64'd1);
        end

        // Round robin across four ports with single-beat packets.
        cycle(1'b1);
        clear_log();
        for (int n = 0; n < 2; n++)
            for (int p = 0; p < NP; p++)
                add_beat(p, 64'(p * 256 + n), 7'h00, 1'b1);
        run(18);
        chk("rr_count", 64'(log_data.size() >= 6), 64'd1);
        k = (log_data.size() < 6) ? log_data.size() : 6;
        for (int i = 0; i < k; i++)
            chk("rr_port", (log_data[i] >> 8) & 64'hF, 64'(i % NP));
        for (int i = 1; i < k; i++)
            chk("rr_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'd2);

        // Stall mid-packet on port 2 while port 1 requests.
        cycle(1'b1);
        clear_log();
        add_pkt(2, 4, 64'h200);
        run(3);
        stall[2] = 1'b1;
        add_beat(1, 64'h100, 7'h11, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0);
            chk("stall_s_ready1", 64'(s_ready[1]), 64'd0);
            chk("stall_grant", 64'(grant_idx), 64'd2);
        end
        stall[2] = 1'b0;
        run(8);
        chk("stall_log_n", 64'(log_data.size()), 64'd5);
        if (log_data.size() == 5) begin
            for (int i = 0; i < 4; i++)
                chk("stall_order", log_data[i], 64'h200 + 64'(i));
            chk("stall_p1_after", log_data[4], 64'h100);
        end

        // Downstream backpressure with a beat held in the output register.
        cycle(1'b1);
        clear_log();
        add_pkt(3, 3, 64'h300);
        run(2);
        ready_pct = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0);
            chk("bp_valid", 64'(m_valid), 64'd1);
            chk("bp_data_stable", 64'(m_data), 64'h300);
            chk("bp_s_ready3", 64'(s_ready[3]), 64'd0);
        end
        ready_pct = 100;
        run(6);
        chk("bp_log_n", 64'(log_data.size()), 64'd3);
        if (log_data.size() == 3)
            for (int i = 0; i < 3; i++)
                chk("bp_order", log_data[i], 64'h300 + 64'(i));

        // Reset during the second beat of a four-beat packet.
        add_pkt(1, 4, 64'h400);
        run(2);
        cycle(1'b1);
        chk("rstmid_m_valid", 64'(m_valid), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_grant", 64'(grant_idx), 64'd3);
        for (int p = 0; p < NP; p++) src_q[p].delete();
        add_beat(0, 64'h500, 7'h00, 1'b1);
        add_beat(2, 64'h502, 7'h00, 1'b1);
        cycle(1'b0);
        chk("rstmid_next_grant", 64'(grant_idx), 64'd0);
        run(6);

        // Source tag on port 3.
        add_beat(3, 64'h3C3C, 7'h7C, 1'b1);
        run(2);
`ifdef AXIS_ARB_SRC_TAG_EN
        exp_user = 64'h7F;
`else
        exp_user = 64'h7C;
`endif
        chk("tag_valid", 64'(m_valid), 64'd1);
        chk("tag_data", 64'(m_data), 64'h3C3C);
        chk("tag_user", 64'(m_user), exp_user);
        run(2);

        // Randomized traffic with random gaps and backpressure.
        valid_pct = 80;
        ready_pct = 70;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) add_rand_pkt();
            cycle(1'b0);
        end
        valid_pct = 100;
        ready_pct = 100;
        pending = 1'b1;
        for (int i = 0; i < 3000 && pending; i++) begin
            pending = m_valid;
            for (int p = 0; p < NP; p++)
                if (src_q[p].size() > 0) pending = 1'b1;
            if (pending) cycle(1'b0);
        end
        chk("random_drain", 64'(pending), 64'd0);
        chk("random_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-level round-robin arbiter that shares one AXI-stream output (data/dest/keep/user/last/valid/ready) between NUM_PORTS stream requesters. It sits between the per-kernel stream sources and the shared network/bridge egress port. Grants are held for a whole packet, delimited by `last`, so beats from different sources never interleave. The output is registered.

## Interface
Parameters:
- NUM_PORTS, 4, number of requesting input streams (2..16)
- DATA_WIDTH, 64, tdata width; keep width is DATA_WIDTH>>3
- DEST_WIDTH, 7, tdest width
- USER_WIDTH, 7, tuser width

Ports:
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- s_data  input  NUM_PORTS*DATA_WIDTH  input data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- s_dest  input  NUM_PORTS*DEST_WIDTH  input dest, same slicing
- s_keep  input  NUM_PORTS*(DATA_WIDTH>>3)  input byte enables
- s_user  input  NUM_PORTS*USER_WIDTH  input user
- s_last  input  NUM_PORTS  end-of-packet per port
- s_valid  input  NUM_PORTS  beat valid per port
- s_ready  output  NUM_PORTS  beat accept per port
- m_data / m_dest / m_keep / m_user  output  DATA_WIDTH / DEST_WIDTH / DATA_WIDTH>>3 / USER_WIDTH  arbitrated beat
- m_last  output  1  end of packet
- m_valid  output  1  output beat valid
- m_ready  input  1  downstream accept
- grant_idx  output  $clog2(NUM_PORTS)  index of current/last granted port (debug)
- busy  output  1  high while a packet is granted

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if any s_valid, pick the first requester scanning (last_grant+1) mod NUM_PORTS upward with wrap. Register grant_idx and go to BUSY. No beat is accepted in IDLE.
- BUSY: s_ready[grant_idx] = ~m_valid | m_ready. All other s_ready bits are 0. An accepted beat (s_valid & s_ready on the granted port) loads the output register and sets m_valid.
- Accepting a beat with s_last=1 returns the FSM to IDLE. last_grant is updated to grant_idx at that point.
- A packet may stall mid-stream (s_valid low). The grant is held indefinitely, and no other port is served.
- Output register: m_valid clears when m_ready & m_valid and no new beat is loaded in the same cycle. Simultaneous drain and load keeps m_valid=1 with the new beat.
- Payload fields pass through unmodified, except as described under Configuration.
- Single-beat packets (s_last on the first beat) are legal and cost one IDLE cycle plus one BUSY cycle.
- Reset values:
  - m_valid, m_last: 0
  - m_data, m_dest, m_keep, m_user: 0
  - s_ready: all 0
  - busy: 0
  - state: IDLE
  - grant_idx and last_grant: NUM_PORTS-1, so port 0 wins the first arbitration.
- Reset mid-packet aborts the packet immediately. The partial packet is dropped from the output register, and no `last` is synthesized.

## Timing
- Arbitration: s_valid seen in IDLE at cycle N gives a grant at N+1. The first beat is accepted at N+1 and appears on m_* at N+2.
- Throughput: one beat per cycle while BUSY with m_ready held high.
- Per-packet overhead: exactly one idle bubble (the IDLE cycle) between packets.
- Latency from input accept to m_valid: 1 cycle.
- s_ready is combinational from m_valid and m_ready. No combinational path from s_valid to s_ready.
- m_* are registers only.

## Configuration
- Macro `AXIS_ARB_SRC_TAG_EN`.
- Defined: m_user[$clog2(NUM_PORTS)-1:0] is replaced by grant_idx on every beat. Upper user bits pass through.
  - Requires USER_WIDTH >= $clog2(NUM_PORTS). An elaboration-time `$error` fires otherwise.
- Undefined: m_user is the source s_user unmodified.

## Test plan
- Single port, 3-beat packet:
  - Stimulus: port 0 sends data 0x11, 0x22, 0x33 (last on 0x33), m_ready=1.
  - Required: m_* shows the same three beats in order, m_last only on 0x33, first m_valid 2 cycles after s_valid rises, busy drops after the last accept.
- Round robin:
  - Stimulus: all 4 ports hold 1-beat packets continuously.
  - Required: grant order 0,1,2,3,0,1, with one bubble between outputs.
- Stall:
  - Stimulus: port 2 drops s_valid for 5 cycles mid-packet while port 1 requests.
  - Required: s_ready[1] stays 0 until port 2's last beat, and no interleaved beats appear.
- Backpressure:
  - Stimulus: m_ready=0 for 4 cycles with m_valid=1.
  - Required: m_* stays stable, s_ready[grant]=0, and no beat is lost or duplicated after m_ready returns.
- Reset mid-packet:
  - Stimulus: assert rst for 1 cycle during beat 2 of a 4-beat packet.
  - Required: m_valid=0 on the next cycle, and the next arbitration grants port 0.
- With AXIS_ARB_SRC_TAG_EN:
  - Stimulus: port 3 sends s_user=7'h7C.
  - Required: m_user=7'h7F (low 2 bits = 3).
